// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the BR resolve unit and its source selector.
package cpu_pkg;

    localparam int DATA_W = 64;
    localparam int REG_W  = 5;

    // XZR reads as zero and is never a real producer, so it never raises a hazard.
    localparam logic [REG_W-1:0] ZERO_REG = 5'd31;

    typedef enum logic [1:0] {
        RESOLVE  = 2'd0,
        WAIT_MEM = 2'd1,
        WAIT_WB  = 2'd2
    } br_state_t;

endpackage

// File: rtl/br_resolve_unit_if.sv
// Bundle of pipeline-side signals for the BR resolve unit.
// There is no valid/ready handshake on this bus: every input is a level sampled
// each cycle, stall is combinational, and redirect/if_flush are one-cycle pulses.
// The slave modport is the resolver, the master modport is the surrounding pipeline.
interface br_resolve_unit_if;
    import cpu_pkg::*;

    logic              id_is_br;
    logic [REG_W-1:0]  id_rn;
    logic [DATA_W-1:0] rf_rdata;
    logic [REG_W-1:0]  idex_rd;
    logic              idex_regwrite;
    logic              idex_memread;
    logic [DATA_W-1:0] ex_result;
    logic [REG_W-1:0]  exmem_rd;
    logic              exmem_regwrite;
    logic              exmem_memread;
    logic [DATA_W-1:0] exmem_result;
    logic              stall;
    logic              redirect;
    logic [DATA_W-1:0] redirect_pc;
    logic              if_flush;
    br_state_t         state;        // FSM state, exposed for debug

    modport slave (
        input  id_is_br, id_rn, rf_rdata,
        input  idex_rd, idex_regwrite, idex_memread, ex_result,
        input  exmem_rd, exmem_regwrite, exmem_memread, exmem_result,
        output stall, redirect, redirect_pc, if_flush, state
    );

    modport master (
        output id_is_br, id_rn, rf_rdata,
        output idex_rd, idex_regwrite, idex_memread, ex_result,
        output exmem_rd, exmem_regwrite, exmem_memread, exmem_result,
        input  stall, redirect, redirect_pc, if_flush, state
    );

endinterface

// File: rtl/br_src_select.sv
// Hazard detection and forwarding mux for the BR source register.
// The newest producer (EX) wins over MEM; with no producer in flight the RF value is used.
module br_src_select
    import cpu_pkg::*;
(
    input  logic [REG_W-1:0]  id_rn,
    input  logic [DATA_W-1:0] rf_rdata,
    input  logic [REG_W-1:0]  idex_rd,
    input  logic              idex_regwrite,
    input  logic              idex_memread,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [REG_W-1:0]  exmem_rd,
    input  logic              exmem_regwrite,
    input  logic              exmem_memread,
    input  logic [DATA_W-1:0] exmem_result,
    output logic              load_in_ex,
    output logic              load_in_mem,
    output logic [DATA_W-1:0] target
);

    logic hit_ex;
    logic hit_mem;

    assign hit_ex  = idex_regwrite  && (idex_rd  == id_rn) && (id_rn != ZERO_REG);
    assign hit_mem = exmem_regwrite && (exmem_rd == id_rn) && (id_rn != ZERO_REG);

    // Classify the youngest matching producer and pick the forwarded value.
    always_comb begin
        load_in_ex  = hit_ex && idex_memread;
        load_in_mem = !hit_ex && hit_mem && exmem_memread;
        if (hit_ex) begin
            target = ex_result;
        end else if (hit_mem) begin
            target = exmem_result;
        end else begin
            target = rf_rdata;
        end
    end

endmodule

// File: rtl/br_resolve_unit.sv
// ID-stage resolver for register-indirect BR: stalls on load-use hazards,
// then registers the branch target and pulses redirect/if_flush for one cycle.
module br_resolve_unit
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    br_resolve_unit_if.slave  bus
);

    br_state_t         state;
    br_state_t         state_nxt;
    logic              stall_fsm;
    logic              fire;
    logic              load_in_ex;
    logic              load_in_mem;
    logic [DATA_W-1:0] target;
    logic              redirect_q;
    logic              if_flush_q;
    logic [DATA_W-1:0] redirect_pc_q;

    br_src_select u_src_select (
        .id_rn          (bus.id_rn),
        .rf_rdata       (bus.rf_rdata),
        .idex_rd        (bus.idex_rd),
        .idex_regwrite  (bus.idex_regwrite),
        .idex_memread   (bus.idex_memread),
        .ex_result      (bus.ex_result),
        .exmem_rd       (bus.exmem_rd),
        .exmem_regwrite (bus.exmem_regwrite),
        .exmem_memread  (bus.exmem_memread),
        .exmem_result   (bus.exmem_result),
        .load_in_ex     (load_in_ex),
        .load_in_mem    (load_in_mem),
        .target         (target)
    );

    // State register; reset aborts any BR in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RESOLVE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, stall and resolve strobe. A BR sitting in IF/ID during the
    // redirect cycle is being squashed, so it is not resolved.
    always_comb begin
        state_nxt = state;
        stall_fsm = 1'b0;
        fire      = 1'b0;
        case (state)
            RESOLVE: begin
                if (bus.id_is_br && !redirect_q) begin
                    if (load_in_ex) begin
                        stall_fsm = 1'b1;
                        state_nxt = WAIT_MEM;
                    end else if (load_in_mem) begin
                        stall_fsm = 1'b1;
                        state_nxt = WAIT_WB;
                    end else begin
                        fire = 1'b1;
                    end
                end
            end
            WAIT_MEM: begin
                // Load data in MEM is not forwarded to ID; wait one more cycle.
                stall_fsm = bus.id_is_br;
                state_nxt = bus.id_is_br ? WAIT_WB : RESOLVE;
            end
            WAIT_WB: begin
                // Load is in WB; RESOLVE picks it up through the write-through RF.
                stall_fsm = bus.id_is_br;
                state_nxt = RESOLVE;
            end
            default: begin
                state_nxt = RESOLVE;
            end
        endcase
    end

    // Registered redirect pulse and target; the target holds between redirects.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redirect_q    <= 1'b0;
            if_flush_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            redirect_q <= fire;
            if_flush_q <= fire;
            if (fire) begin
                redirect_pc_q <= target;
            end
        end
    end

    // Stall is forced low while reset is held so the front end is released at once.
    assign bus.stall       = stall_fsm && !reset;
    assign bus.redirect    = redirect_q;
    assign bus.if_flush    = if_flush_q;
    assign bus.redirect_pc = redirect_pc_q;
    assign bus.state       = state;

endmodule
